// File: rtl/irq_pkg.sv
// irq_pkg: shared FSM state type and config register addresses for the interrupt controller
package irq_pkg;
  typedef enum logic {IRQ_IDLE, IRQ_ACTIVE} irq_state_e;
  localparam logic [1:0] IRQ_ADDR_ENABLE   = 2'd0;
  localparam logic [1:0] IRQ_ADDR_MODE     = 2'd1;
  localparam logic [1:0] IRQ_ADDR_PEND_CLR = 2'd2;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational lowest-index priority encoder (vec -> id of lowest set bit, found=|vec)
module irq_prio_enc #(
  parameter int N    = 8,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    vec,
  output logic [ID_W-1:0] id,
  output logic            found
);
  always_comb begin
    id    = '0;
    found = |vec;
    for (int i = N - 1; i >= 0; i--)
      if (vec[i]) id = ID_W'(i);
  end
endmodule

// File: rtl/irq_controller.sv
// irq_controller: latches/masks interrupt requests, raises irq_out, serves claim/complete; IRQ_SYNC_EN adds a 2-flop input synchroniser
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               wr_en,
  input  logic [1:0]         wr_addr,
  input  logic [31:0]        wr_data,
  output logic               irq_out,
  input  logic               claim,
  output logic               claim_valid,
  output logic               claim_empty,
  output logic [ID_W-1:0]    claim_id,
  input  logic               complete,
  input  logic [ID_W-1:0]    complete_id,
  output logic [NUM_SRC-1:0] pending
);
  irq_state_e         state;
  logic [NUM_SRC-1:0] src_s, src_q, enable, mode, masked, set_v, clr_v, claim_clr;
  logic [ID_W-1:0]    enc_id, act_id;
  logic               enc_found, grant, unused_wr;
`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      src_s <= '0;
    end else begin
      sync1 <= src_irq;
      src_s <= sync1;
    end
  end
`else
  assign src_s = src_irq;
`endif
  assign unused_wr = ^wr_data;
  irq_prio_enc #(.N(NUM_SRC), .ID_W(ID_W)) u_enc (.vec(masked), .id(enc_id), .found(enc_found));
  assign masked    = pending & enable;
  // edge mode sets only on a rising edge, level mode every cycle the line is high
  assign set_v     = src_s & (~mode | ~src_q);
  assign clr_v     = (wr_en && wr_addr == IRQ_ADDR_PEND_CLR) ? wr_data[NUM_SRC-1:0] : '0;
  assign grant     = state == IRQ_IDLE && claim && enc_found;
  assign claim_clr = grant ? NUM_SRC'(1) << enc_id : '0;
  assign irq_out   = state == IRQ_IDLE && |masked;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IRQ_IDLE;
      src_q       <= '0;
      enable      <= '0;
      mode        <= '0;
      pending     <= '0;
      act_id      <= '0;
      claim_valid <= 1'b0;
      claim_empty <= 1'b0;
      claim_id    <= '0;
    end else begin
      src_q       <= src_s;
      // new requests win over any clear in the same cycle
      pending     <= (pending & ~clr_v & ~claim_clr) | set_v;
      if (wr_en && wr_addr == IRQ_ADDR_ENABLE) enable <= wr_data[NUM_SRC-1:0];
      if (wr_en && wr_addr == IRQ_ADDR_MODE) mode <= wr_data[NUM_SRC-1:0];
      claim_valid <= claim;
      claim_empty <= claim && !grant;
      claim_id    <= grant ? enc_id : '0;
      if (grant) begin
        state  <= IRQ_ACTIVE;
        act_id <= enc_id;
      end else if (state == IRQ_ACTIVE && complete && complete_id == act_id) begin
        state  <= IRQ_IDLE;
      end
    end
  end
endmodule
